// File: rtl/d_en_latch.sv
// Level-sensitive gated D latch bank with complementary outputs.
// Async active-high reset R loads RESET_VAL; transparent while C is high.
module d_en_latch #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = D;

  // Single storage node per bit: reset dominates, otherwise follow D while C is high.
  always_latch begin
    if (R) begin
      q_q <= RESET_VAL;
    end else if (C) begin
      q_q <= q_d;
    end
  end

  // Both outputs come from the same node, so Q and Qn can never agree.
  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: tb/tb_d_en_latch.sv
// Scoreboard bench for d_en_latch: a 1-bit and an 8-bit (RESET_VAL=8'hA5) instance
// driven from shared C/R, checked against a rule-level model via an expectation queue.
module tb_d_en_latch;

  logic       c;
  logic       r;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic       qn1;
  logic [7:0] q8;
  logic [7:0] qn8;

  typedef struct {
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  push_ev;

  logic       m_q1;
  logic [7:0] m_q8;
  int         check_cnt;
  int         pass_cnt;
  logic       prev_c;

  d_en_latch #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .C(c), .R(r), .D(d1), .Q(q1), .Qn(qn1)
  );

  d_en_latch #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .C(c), .R(r), .D(d8), .Q(q8), .Qn(qn8)
  );

  task automatic check1(input string nm, input logic act, input logic req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %b, required %b at %0t", nm, act, req, $time);
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
  endtask

  // Monitor: after each stimulus event, let outputs settle and compare against the queue.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(push_ev);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check1({nm, ".Q1"},  q1,  e.q1);
        check1({nm, ".Qn1"}, qn1, ~e.q1);
        check8({nm, ".Q8"},  q8,  e.q8);
        check8({nm, ".Qn8"}, qn8, ~e.q8);
      end
    end
  end

  // Apply inputs, advance the model by the latch rules, queue the expectation, then hold.
  task automatic step(input logic nc, input logic nr, input logic nd1,
                      input logic [7:0] nd8, input int hold, input string nm);
    exp_t e;
    c  = nc;
    r  = nr;
    d1 = nd1;
    d8 = nd8;
    if (nr) begin
      m_q1 = 1'b0;
      m_q8 = 8'hA5;
    end else if (nc) begin
      m_q1 = nd1;
      m_q8 = nd8;
    end
    e.q1 = m_q1;
    e.q8 = m_q8;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> push_ev;
    #(hold);
    prev_c = nc;
  endtask

  initial begin
    logic       rc;
    logic       rr;
    logic       rd1;
    logic [7:0] rd8;
    check_cnt = 0;
    pass_cnt  = 0;
    m_q1      = 1'b0;
    m_q8      = 8'h00;
    prev_c    = 1'b0;
    c  = 1'b0;
    r  = 1'b1;
    d1 = 1'b1;
    d8 = 8'hFF;
    #1;

    // Reset dominates while C toggles and D is all ones.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 5, "rst_c0");
    step(1'b1, 1'b1, 1'b1, 8'hFF, 5, "rst_c1");
    step(1'b0, 1'b1, 1'b1, 8'hFF, 5, "rst_c0b");
    step(1'b0, 1'b0, 1'b1, 8'hFF, 10, "rel_c0");

    // Transparency.
    step(1'b1, 1'b0, 1'b0, 8'h00, 10, "tr_d0");
    step(1'b1, 1'b0, 1'b1, 8'h5A, 10, "tr_d1");
    step(1'b1, 1'b0, 1'b0, 8'hC3, 10, "tr_d0b");

    // Hold phase then re-open.
    step(1'b1, 1'b0, 1'b1, 8'h3C, 10, "hold_set");
    step(1'b0, 1'b0, 1'b1, 8'h3C, 10, "hold_fall");
    step(1'b0, 1'b0, 1'b0, 8'hFF, 40, "hold_d0");
    step(1'b1, 1'b0, 1'b0, 8'hFF, 10, "hold_rise");

    // Staggered schedule: D at 40+100k, C rise 50+100k, C fall 100+100k.
    step(1'b0, 1'b0, 1'b0, 8'h00, 40, "stag_init");
    for (int k = 0; k < 5; k++) begin
      logic       sd1;
      logic [7:0] sd8;
      sd1 = (k % 2 == 0);
      sd8 = 8'(8'h11 * (k + 1));
      step(1'b0, 1'b0, sd1, sd8, 10, $sformatf("stag_d%0d", k));
      step(1'b1, 1'b0, sd1, sd8, 50, $sformatf("stag_rise%0d", k));
      step(1'b0, 1'b0, sd1, sd8, 40, $sformatf("stag_fall%0d", k));
    end

    // Reset pulse mid-transparent, then recovery with C still high.
    step(1'b1, 1'b0, 1'b1, 8'h77, 10, "mid_tr");
    step(1'b1, 1'b1, 1'b1, 8'h77, 5, "mid_rst");
    step(1'b1, 1'b0, 1'b1, 8'h77, 10, "mid_rel");

    // Randomized traffic; D is kept stable on any step where C falls.
    for (int i = 0; i < 200; i++) begin
      rc  = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 15) == 0);
      rd1 = 1'($urandom_range(0, 1));
      rd8 = 8'($urandom);
      if (prev_c && !rc) begin
        rd1 = d1;
        rd8 = d8;
      end
      step(rc, rr, rd1, rd8, 5, $sformatf("rnd%0d", i));
    end

    // Drain with a bound.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      check_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
